sbox_seq_ctrl: RTL and testbench
================================

SBOX_SEQ_CTRL -- requirements
Module: sbox_seq_ctrl

Interface
REQ-001 Parameter: NUM_BOX, default 8, number of 6-bit groups sequenced per operation; fixed at 8 for DES.
REQ-002 Parameter: ABORT_CLR, default 1, when 1 an abort clears the DOUT register to 0; when 0 DOUT holds its previous value.
REQ-003 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Port: RST_N  input  1  reset, asynchronous, active-low.
REQ-005 Port: START  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 Port: DIN  input  48  expanded/keyed round data; DIN[47:42] feeds box 0 ... DIN[5:0] feeds box 7.
REQ-007 Port: ROM_SEL  output  3  index of the S-box ROM being addressed (0..7).
REQ-008 Port: ROM_ADDR  output  6  6-bit S-box input, bit order matching DIN group (row/column decode is done in the ROM).
REQ-009 Port: ROM_DATA  input  4  combinational ROM result for the current ROM_SEL/ROM_ADDR.
REQ-010 Port: DOUT  output  32  assembled result; box 0 in DOUT[31:28] ... box 7 in DOUT[3:0].
REQ-011 Port: BUSY  output  1  high in RUN and DONE states.
REQ-012 Port: DONE  output  1  single-cycle pulse marking DOUT valid.
REQ-013 Port: ABORT  input  1  present only when SBOX_SEQ_ABORT_EN is defined.

Function
REQ-014 FSM states: IDLE, RUN, DONE; encoding is free.
REQ-015 IDLE, START=1 at an edge: latch DIN into a 48-bit register, clear counter CNT (3 bits), go to RUN.
REQ-016 IDLE, START=0: remain in IDLE; ROM_SEL=0, ROM_ADDR=0.
REQ-017 RUN: ROM_SEL=CNT, ROM_ADDR=latched group CNT, both driven from registers/CNT only (no DIN path).
REQ-018 RUN: each edge captures ROM_DATA into accumulator nibble CNT, then CNT increments.
REQ-019 RUN lasts exactly 8 cycles; the edge that captures CNT=7 moves the FSM to DONE and loads the full accumulator into DOUT in the same edge.
REQ-020 DONE: DONE=1 for exactly one cycle; next edge returns to IDLE unconditionally.
REQ-021 Latency: START sampled at edge E0 -> DONE high in the cycle after edge E8; throughput one operation per 10 cycles.
REQ-022 START is ignored in RUN and DONE; no queuing, no error flag.
REQ-023 DOUT changes only on the RUN->DONE edge (or on abort/reset); it holds between operations.
REQ-024 DIN changes after E0 do not affect the current operation.
REQ-025 CNT wrap 7->0 coincides with the RUN->DONE transition; CNT is never used outside RUN.

Reset
REQ-026 RST_N low asynchronously forces IDLE, CNT=0, DIN latch=0, accumulator=0, DOUT=0, DONE=0, BUSY=0, ROM_SEL=0, ROM_ADDR=0.
REQ-027 Reset asserted mid-RUN discards the operation with no DONE pulse; first START after release begins a fresh operation.

Configuration
REQ-028 Macro SBOX_SEQ_ABORT_EN defined: ABORT port exists; ABORT=1 in RUN or DONE returns the FSM to IDLE on the next edge with no DONE pulse, and DOUT is cleared if ABORT_CLR=1; ABORT is ignored in IDLE and has priority over START.
REQ-029 Macro SBOX_SEQ_ABORT_EN undefined: no ABORT port, and operations always run to completion.

Verification
REQ-030 Bench ROM returns ROM_SEL+1, START with any DIN -> ROM_SEL steps 0..7 on consecutive cycles, DONE one cycle after E8, DOUT=32'h12345678.
REQ-031 Real DES S4 table on box 3, DIN group 3 = 6'b000000, other boxes return 0 -> DOUT=32'h00070000.
REQ-032 START held high continuously -> operations start on edges E0, E10, E20; exactly one DONE pulse per 10 cycles.
REQ-033 RST_N low at CNT=4 -> all outputs 0 immediately, no DONE; START after release -> normal 8-cycle result.
REQ-034 DIN toggled every cycle during RUN -> DOUT reflects DIN value at E0 only.
REQ-035 SBOX_SEQ_ABORT_EN defined, ABORT=1 at CNT=5 -> IDLE next edge, DONE never asserted, DOUT=0 (ABORT_CLR=1) or previous value (ABORT_CLR=0).

Source files
------------

// File: rtl/sbox_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : sbox_seq_ctrl
//  Purpose  : Sequences the eight DES S-box lookups of one round through a
//             single shared, combinational S-box ROM. The 48-bit round data is
//             latched on START, one 6-bit group is presented per cycle, the
//             4-bit results are gathered into an accumulator, and the
//             assembled 32-bit word is published on DOUT with a DONE pulse.
//
//  Ports    : clk       in   1    clock, rising edge
//             rst_n     in   1    asynchronous active-low reset
//             start     in   1    begin an operation (sampled in IDLE only)
//             din       in   48   round data, group 0 in din[47:42]
//             rom_sel   out  3    S-box ROM index being addressed
//             rom_addr  out  6    S-box input for the addressed ROM
//             rom_data  in   4    combinational ROM result
//             dout      out  32   assembled result, box 0 in dout[31:28]
//             busy      out  1    high while RUN or DONE
//             done      out  1    one-cycle pulse, dout valid
//             abort     in   1    only with SBOX_SEQ_ABORT_EN defined
//
//  Config   : SBOX_SEQ_ABORT_EN - adds the abort port and abort handling.
//             Default build (macro undefined) always runs to completion.
//
//  Revision : 1.0 - initial release
// ============================================================================
module sbox_seq_ctrl #(
    parameter int NUM_BOX   = 8,
    parameter bit ABORT_CLR = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [6*NUM_BOX-1:0]   din,
    output logic [2:0]             rom_sel,
    output logic [5:0]             rom_addr,
    input  logic [3:0]             rom_data,
    output logic [4*NUM_BOX-1:0]   dout,
    output logic                   busy,
    output logic                   done
`ifdef SBOX_SEQ_ABORT_EN
    ,
    input  logic                   abort
`endif
);

    localparam int                 c_CNT_W    = (NUM_BOX > 1) ? $clog2(NUM_BOX) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(NUM_BOX - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [6*NUM_BOX-1:0]   r_din;
    logic [3:0]             r_acc [NUM_BOX];
    logic [4*NUM_BOX-1:0]   r_dout;

    logic                   w_abort;
    logic                   w_load;
    logic                   w_step;
    logic                   w_finish;
    logic                   w_abort_hit;
    logic [5:0]             w_group [NUM_BOX];
    logic [4*NUM_BOX-1:0]   w_dout_next;

`ifdef SBOX_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Split the latched data into its 6-bit groups, group 0 at the top.
    generate
        for (genvar g = 0; g < NUM_BOX; g++) begin : g_group
            assign w_group[g] = r_din[(NUM_BOX-1-g)*6 +: 6];
        end
    endgenerate

    // The final box result is taken straight from the ROM so the full word
    // can be loaded into dout on the same edge that captures it.
    generate
        for (genvar g = 0; g < NUM_BOX; g++) begin : g_pack
            if (g == NUM_BOX - 1) begin : g_last
                assign w_dout_next[(NUM_BOX-1-g)*4 +: 4] = rom_data;
            end else begin : g_acc
                assign w_dout_next[(NUM_BOX-1-g)*4 +: 4] = r_acc[g];
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        w_abort_hit  = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        rom_sel      = 3'd0;
        rom_addr     = 6'd0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy     = 1'b1;
                rom_sel  = 3'(r_cnt);
                rom_addr = w_group[r_cnt];
                // Abort wins over both the capture and any start request.
                if (w_abort) begin
                    w_abort_hit  = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        w_finish     = 1'b1;
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_abort_hit  = w_abort;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: input latch, box counter, accumulator, result register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_din  <= '0;
            r_dout <= '0;
            for (int i = 0; i < NUM_BOX; i++) begin
                r_acc[i] <= 4'd0;
            end
        end else begin
            if (w_load) begin
                r_din <= din;
                r_cnt <= '0;
            end else if (w_step) begin
                r_acc[r_cnt] <= rom_data;
                // Wrap explicitly so the count is back at zero on RUN exit.
                r_cnt <= w_finish ? '0 : r_cnt + c_CNT_W'(1);
            end

            if (w_finish) begin
                r_dout <= w_dout_next;
            end else if (w_abort_hit && ABORT_CLR) begin
                r_dout <= '0;
            end
        end
    end

    assign dout = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_sbox_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
module tb_sbox_seq_ctrl;

    localparam bit c_ABORT_CLR = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [47:0] din;
    logic [2:0]  rom_sel;
    logic [5:0]  rom_addr;
    logic [3:0]  rom_data;
    logic [31:0] dout;
    logic        busy;
    logic        done;
`ifdef SBOX_SEQ_ABORT_EN
    logic        abort;
`endif

    int          mode = 0;
    int          seed = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_dout = 32'd0;

    typedef struct {int cyc; logic [31:0] val;} exp_t;
    typedef struct {int cyc; logic [2:0] sel; logic [5:0] addr;} rom_t;
    exp_t exp_q[$];
    rom_t rom_q[$];

    sbox_seq_ctrl #(
        .NUM_BOX   (8),
        .ABORT_CLR (c_ABORT_CLR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .din      (din),
        .rom_sel  (rom_sel),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .dout     (dout),
        .busy     (busy),
        .done     (done)
`ifdef SBOX_SEQ_ABORT_EN
        ,
        .abort    (abort)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DES S-box 4; row = {a5,a0}, column = a4..a1, column 0 in the top nibble.
    function automatic logic [3:0] s4(input logic [5:0] a);
        logic [63:0] row;
        case ({a[5], a[0]})
            2'd0:    row = 64'h7DE3069A1285BC4F;
            2'd1:    row = 64'hD8B56F03472C1AE9;
            2'd2:    row = 64'hA690CB7DF13E5284;
            default: row = 64'h3F06A1D8945BC72E;
        endcase
        return row[(15 - int'(a[4:1]))*4 +: 4];
    endfunction

    // Bench ROM: 0 = sel+1, 1 = real S4 on box 3 only, other = hashed table.
    function automatic logic [3:0] rom_fn(input int m, input int sd,
                                          input logic [2:0] s, input logic [5:0] a);
        case (m)
            0:       return 4'(s) + 4'd1;
            1:       return (s == 3'd3) ? s4(a) : 4'd0;
            default: return 4'(((int'(a) * 7) ^ (int'(a) >> 2) ^ (int'(s) * 11) ^ sd) & 15);
        endcase
    endfunction

    assign rom_data = rom_fn(mode, seed, rom_sel, rom_addr);

    // Reference: box b looks up DIN group b and lands in nibble b from the top.
    function automatic logic [31:0] model(input logic [47:0] d);
        logic [31:0] r;
        r = 32'd0;
        for (int b = 0; b < 8; b++) begin
            r[(7-b)*4 +: 4] = rom_fn(mode, seed, 3'(b), d[(7-b)*6 +: 6]);
        end
        return r;
    endfunction

    function automatic logic [47:0] rnd48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor: pops expectations when the DUT presents them
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (rom_q.size() > 0 && rom_q[0].cyc == cyc) begin
                rom_t r;
                r = rom_q.pop_front();
                chk("rom_sel", 48'(rom_sel), 48'(r.sel));
                chk("rom_addr", 48'(rom_addr), 48'(r.addr));
                chk("busy_run", 48'(busy), 48'd1);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 48'(done), 48'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_cycle", 48'(cyc), 48'(e.cyc));
                    chk("dout", 48'(dout), 48'(e.val));
                    chk("busy_done", 48'(busy), 48'd1);
                    last_dout = e.val;
                end
            end else begin
                if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("missing_done", 48'(cyc), 48'(e.cyc));
                end
                chk("dout_hold", 48'(dout), 48'(last_dout));
            end
        end
    end

    // kind: 0 = quiet, 1 = noisy START/DIN during the operation, 2 = START held high
    task automatic do_op(input logic [47:0] d, input logic [31:0] expv, input int kind);
        @(negedge clk);
        start = 1'b1;
        din   = d;
        exp_q.push_back(exp_t'{cyc + 9, expv});
        for (int k = 0; k < 8; k++) begin
            rom_q.push_back(rom_t'{cyc + 1 + k, 3'(k), d[(7-k)*6 +: 6]});
        end
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            case (kind)
                1:       begin start = 1'($urandom); din = rnd48(); end
                2:       start = 1'b1;
                default: start = 1'b0;
            endcase
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start = 1'b0;
            din   = rnd48();
        end
    endtask

    task automatic reset_mid();
        logic [47:0] d;
        d = rnd48();
        @(negedge clk);
        start = 1'b1;
        din   = d;
        for (int k = 0; k < 5; k++) begin
            rom_q.push_back(rom_t'{cyc + 1 + k, 3'(k), d[(7-k)*6 +: 6]});
        end
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        rom_q.delete();
        last_dout = 32'd0;
        #1;
        chk("rst_mid_dout", 48'(dout), 48'd0);
        chk("rst_mid_done", 48'(done), 48'd0);
        chk("rst_mid_busy", 48'(busy), 48'd0);
        chk("rst_mid_sel", 48'(rom_sel), 48'd0);
        chk("rst_mid_addr", 48'(rom_addr), 48'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

`ifdef SBOX_SEQ_ABORT_EN
    task automatic abort_mid();
        logic [47:0] d;
        d = rnd48();
        @(negedge clk);
        start = 1'b1;
        din   = d;
        for (int k = 0; k < 6; k++) begin
            rom_q.push_back(rom_t'{cyc + 1 + k, 3'(k), d[(7-k)*6 +: 6]});
        end
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        abort = 1'b1;
        start = 1'b1;
        if (c_ABORT_CLR) last_dout = 32'd0;
        @(negedge clk);
        #2;
        abort = 1'b0;
        start = 1'b0;
        chk("abort_busy", 48'(busy), 48'd0);
        chk("abort_done", 48'(done), 48'd0);
        chk("abort_dout", 48'(dout), 48'(last_dout));
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, limit 100000 ns");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        logic [47:0] d;
        rst_n = 1'b0;
        start = 1'b0;
        din   = 48'd0;
`ifdef SBOX_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        chk("reset_dout", 48'(dout), 48'd0);
        chk("reset_done", 48'(done), 48'd0);
        chk("reset_busy", 48'(busy), 48'd0);
        chk("reset_sel", 48'(rom_sel), 48'd0);
        chk("reset_addr", 48'(rom_addr), 48'd0);
        #1;
        rst_n = 1'b1;

        // Incrementing ROM gives a fixed, recognisable word.
        mode = 0;
        do_op(rnd48(), 32'h12345678, 0);
        idle(2);

        // Real S4 on box 3 with a zero input group.
        mode = 1;
        d = rnd48();
        d[(7-3)*6 +: 6] = 6'd0;
        do_op(d, 32'h00070000, 0);
        idle(1);

        // START held high: back-to-back operations every 10 cycles.
        mode = 2;
        seed = int'($urandom_range(0, 15));
        for (int i = 0; i < 3; i++) begin
            d = rnd48();
            do_op(d, model(d), 2);
        end
        idle(3);

        reset_mid();
        d = rnd48();
        do_op(d, model(d), 0);
        idle(1);

        // Random operations with DIN and START toggling during RUN.
        for (int i = 0; i < 15; i++) begin
            seed = int'($urandom_range(0, 15));
            d = rnd48();
            do_op(d, model(d), 1);
            idle(int'($urandom_range(0, 2)));
        end

`ifdef SBOX_SEQ_ABORT_EN
        abort_mid();
        d = rnd48();
        do_op(d, model(d), 0);
`endif

        idle(12);
        chk("exp_queue_empty", 48'(exp_q.size()), 48'd0);
        chk("rom_queue_empty", 48'(rom_q.size()), 48'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
